// File: rtl/bp_me_wormhole_packet_deserializer.sv
// bp_me_wormhole_packet_deserializer: reassembles wormhole flits into one packet and drops oversized or misrouted packets
module bp_me_wormhole_packet_deserializer #(
  parameter int flit_width_p = 64,
  parameter int cord_width_p = 7,
  parameter int len_width_p = 4,
  parameter int max_packet_width_p = 640
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [cord_width_p-1:0]       my_cord_i,
  input  logic [flit_width_p-1:0]       flit_i,
  input  logic                          v_i,
  output logic                          ready_and_o,
  output logic [max_packet_width_p-1:0] packet_o,
  output logic                          v_o,
  input  logic                          yumi_i,
  output logic                          err_o
);
  localparam int max_flits_lp = (max_packet_width_p + flit_width_p - 1) / flit_width_p;
  typedef enum logic [1:0] {e_idle, e_body, e_drain, e_full} state_e;
  state_e state, state_n;
  logic [len_width_p-1:0] cnt, len_r, hdr_len;
  logic [max_flits_lp-1:0][flit_width_p-1:0] slots;
  logic [max_flits_lp*flit_width_p-1:0] flat;
  logic accept, good, err, err_n;
  assign hdr_len = flit_i[cord_width_p +: len_width_p];
  assign good = (hdr_len <= len_width_p'(max_flits_lp - 1)) && (flit_i[cord_width_p-1:0] == my_cord_i);
  assign ready_and_o = (state != e_full);
  assign accept = v_i & ready_and_o;
  assign v_o = (state == e_full);
  assign err_o = err;
  assign flat = slots;
  assign packet_o = flat[max_packet_width_p-1:0];
  always_comb begin
    state_n = state;
    err_n = 1'b0;
    case (state)
      e_idle: if (accept) begin
        state_n = good ? (hdr_len == '0 ? e_full : e_body) : (hdr_len == '0 ? e_idle : e_drain);
        err_n = !good && hdr_len == '0;
      end
      e_body: state_n = (accept && cnt == len_r) ? e_full : e_body;
      e_drain: if (accept && cnt == len_width_p'(1)) begin
        state_n = e_idle;
        err_n = 1'b1;
      end
      default: state_n = yumi_i ? e_idle : e_full;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= e_idle;
      cnt <= '0;
      len_r <= '0;
      err <= 1'b0;
      slots <= '0;
    end else begin
      state <= state_n;
      err <= err_n;
      if (accept) begin
        if (state == e_idle) begin
          len_r <= hdr_len;
          cnt <= good ? len_width_p'(1) : hdr_len;
          if (good) begin
            slots <= '0;
            slots[0] <= flit_i;
          end
        end else if (state == e_body) begin
          slots[cnt] <= flit_i;
          cnt <= cnt + 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end
  // a consumer taking a packet that is not offered violates the handshake
  always_ff @(posedge clk_i) if (reset_n_i && yumi_i) assert (v_o);
endmodule

// File: tb/tb_bp_me_wormhole_packet_deserializer.sv
// tb_bp_me_wormhole_packet_deserializer: directed vectors and multi-cycle sequences for the deserializer
module tb_bp_me_wormhole_packet_deserializer;
  logic clk = 1'b0;
  logic reset_n_i = 1'b0;
  logic [6:0] my_cord_i = 7'd5;
  logic [63:0] flit_i = '0;
  logic v_i = 1'b0;
  logic ready_and_o;
  logic [639:0] packet_o;
  logic v_o;
  logic yumi_i = 1'b0;
  logic err_o;
  int pass = 0;
  int total = 0;

  bp_me_wormhole_packet_deserializer dut (
    .clk_i(clk), .reset_n_i(reset_n_i), .my_cord_i(my_cord_i), .flit_i(flit_i), .v_i(v_i),
    .ready_and_o(ready_and_o), .packet_o(packet_o), .v_o(v_o), .yumi_i(yumi_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  cord;
    logic [52:0] pay;
    logic        ev;
    logic        ee;
  } vec_t;

  function automatic logic [63:0] hdr(logic [52:0] p, logic [3:0] l, logic [6:0] c);
    return {p, l, c};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string n, logic [639:0] a, logic [639:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else pass++;
  endtask

  task automatic send(logic [63:0] f);
    flit_i = f;
    v_i = 1'b1;
    step();
    v_i = 1'b0;
  endtask

  task automatic take();
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
  endtask

  vec_t tbl[4];
  logic [639:0] exp_pkt;
  logic [63:0] f;
  int errs;

  initial begin
    tbl[0] = '{cord: 7'd5, pay: 53'hA5, ev: 1'b1, ee: 1'b0};
    tbl[1] = '{cord: 7'd4, pay: 53'hA5, ev: 1'b0, ee: 1'b1};
    tbl[2] = '{cord: 7'd5, pay: 53'h1F_FFFF_1234_5678, ev: 1'b1, ee: 1'b0};
    tbl[3] = '{cord: 7'd0, pay: 53'h77, ev: 1'b0, ee: 1'b1};

    step();
    step();
    chk("rst_ready", 640'(ready_and_o), 640'(1));
    chk("rst_v", 640'(v_o), 640'(0));
    chk("rst_err", 640'(err_o), 640'(0));
    chk("rst_packet", packet_o, '0);
    reset_n_i = 1'b1;
    step();

    for (int i = 0; i < 4; i++) begin
      f = hdr(tbl[i].pay, 4'd0, tbl[i].cord);
      send(f);
      chk($sformatf("tbl%0d_v", i), 640'(v_o), 640'(tbl[i].ev));
      chk($sformatf("tbl%0d_err", i), 640'(err_o), 640'(tbl[i].ee));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_pkt", i), packet_o, 640'(f));
        chk($sformatf("tbl%0d_ready_full", i), 640'(ready_and_o), 640'(0));
        take();
        chk($sformatf("tbl%0d_v_after", i), 640'(v_o), 640'(0));
        chk($sformatf("tbl%0d_ready_after", i), 640'(ready_and_o), 640'(1));
      end else begin
        step();
        chk($sformatf("tbl%0d_err_after", i), 640'(err_o), 640'(0));
      end
    end

    exp_pkt = '0;
    for (int k = 0; k < 10; k++) begin
      f = (k == 0) ? hdr(53'd1, 4'd9, 7'd5) : 64'(k + 1);
      exp_pkt[k*64 +: 64] = f;
      flit_i = f;
      v_i = 1'b1;
      step();
      if (k < 9) chk($sformatf("max_v_early%0d", k), 640'({v_o, ready_and_o}), 640'(2'b01));
    end
    v_i = 1'b0;
    chk("max_v", 640'(v_o), 640'(1));
    chk("max_pkt", packet_o, exp_pkt);
    step();
    step();
    chk("max_hold_ready", 640'(ready_and_o), 640'(0));
    chk("max_hold_pkt", packet_o, exp_pkt);
    take();
    chk("max_after", 640'({v_o, ready_and_o}), 640'(2'b01));

    exp_pkt = '0;
    exp_pkt[63:0] = hdr(53'hBEEF, 4'd2, 7'd5);
    exp_pkt[127:64] = 64'h1111_2222_3333_4444;
    exp_pkt[191:128] = 64'h5555_6666_7777_8888;
    for (int k = 0; k < 3; k++) begin
      send(exp_pkt[k*64 +: 64]);
      if (k < 2) begin
        step();
        step();
        chk($sformatf("bp_stall_v%0d", k), 640'(v_o), 640'(0));
      end
    end
    chk("bp_v", 640'(v_o), 640'(1));
    chk("bp_pkt", packet_o, exp_pkt);
    f = hdr(53'hC0DE, 4'd0, 7'd5);
    flit_i = f;
    v_i = 1'b1;
    for (int k = 0; k < 5; k++) step();
    chk("bp_hold_ready", 640'(ready_and_o), 640'(0));
    chk("bp_hold_pkt", packet_o, exp_pkt);
    chk("bp_hold_v", 640'(v_o), 640'(1));
    yumi_i = 1'b1;
    step();
    yumi_i = 1'b0;
    chk("bp_yumi", 640'({v_o, ready_and_o}), 640'(2'b01));
    step();
    v_i = 1'b0;
    chk("bp_next_v", 640'(v_o), 640'(1));
    chk("bp_next_pkt", packet_o, 640'(f));
    take();

    errs = 0;
    for (int k = 0; k < 13; k++) begin
      send(k == 0 ? hdr(53'h9, 4'd12, 7'd5) : 64'(k));
      errs += int'(err_o);
      chk($sformatf("ovs_v%0d", k), 640'(v_o), 640'(0));
    end
    chk("ovs_err_last", 640'(err_o), 640'(1));
    step();
    chk("ovs_err_count", 640'(errs), 640'(1));
    chk("ovs_err_after", 640'(err_o), 640'(0));
    exp_pkt = '0;
    exp_pkt[63:0] = hdr(53'h42, 4'd1, 7'd5);
    exp_pkt[127:64] = 64'hFEED_FACE_0BAD_F00D;
    send(exp_pkt[63:0]);
    send(exp_pkt[127:64]);
    chk("ovs_good_v", 640'(v_o), 640'(1));
    chk("ovs_good_pkt", packet_o, exp_pkt);
    take();

    errs = 0;
    for (int k = 0; k < 3; k++) begin
      send(k == 0 ? hdr(53'h3, 4'd2, 7'd6) : 64'(k + 100));
      errs += int'(err_o);
    end
    step();
    errs += int'(err_o);
    chk("mis_err_count", 640'(errs), 640'(1));
    chk("mis_v", 640'(v_o), 640'(0));

    send(hdr(53'h5, 4'd4, 7'd5));
    send(64'h1234);
    reset_n_i = 1'b0;
    step();
    chk("mid_rst", 640'({ready_and_o, v_o, err_o}), 640'(3'b100));
    chk("mid_rst_pkt", packet_o, '0);
    reset_n_i = 1'b1;
    exp_pkt = '0;
    exp_pkt[63:0] = hdr(53'h33, 4'd1, 7'd5);
    exp_pkt[127:64] = 64'hDEAD;
    send(exp_pkt[63:0]);
    chk("mid_hdr_v", 640'(v_o), 640'(0));
    send(exp_pkt[127:64]);
    chk("mid_v", 640'(v_o), 640'(1));
    chk("mid_pkt", packet_o, exp_pkt);
    take();

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
